demux_stream_sched: RTL and testbench

- Scheduler that sequences a shared 1xN demux datapath.
- Accepts words on a single valid/ready input stream and steers each word to exactly one of NUM_OUT output channels.
- Destination is either explicit (in_dest) or round-robin.
- Sits in front of the demux1x2-style steering logic: owns the select and drives the per-output valid/ready handshakes.

---
 rtl/demux_stream_sched_if.sv | 33 +++
 rtl/demux_stream_sched.sv | 120 ++++++++++++
 tb/tb_demux_stream_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_sched_if.sv
// Stream-in / demux-out handshake bundle for demux_stream_sched.
// slave = scheduler side, master = producer/consumer side.
interface demux_stream_sched_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SEL_W-1:0]   in_dest;
  logic               in_auto;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               err;
  logic [15:0]        xfer_cnt;
  logic               busy;

  modport slave (
    input  in_valid, in_data, in_dest, in_auto,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output err, xfer_cnt, busy
  );

  modport master (
    output in_valid, in_data, in_dest, in_auto,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  err, xfer_cnt, busy
  );
endinterface

// File: rtl/demux_stream_sched.sv
// Scheduler for a shared 1xN demux: one input stream, N outputs.
// Optional SEND timeout enabled by macro DEMUX_SCHED_TIMEOUT_EN.
module demux_stream_sched #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  demux_stream_sched_if.slave bus
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [NUM_OUT-1:0] ONE =
    NUM_OUT'(1);
  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(NUM_OUT - 1);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] dest_q;
  logic             auto_q;

  logic [SEL_W-1:0] dest_sel;
  logic [SEL_W-1:0] rr_nxt;
  logic             dest_ok;
  logic             take;
  logic             hit;

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
`endif

  // destination pick, legality and pointer wrap
  always_comb begin
    dest_sel = bus.in_auto ? rr_ptr
                           : bus.in_dest;
    dest_ok  = bus.in_auto ||
               (32'(bus.in_dest) < NUM_OUT);
    rr_nxt   = (rr_ptr == LAST) ? '0
                                : rr_ptr + 1'b1;
    take     = bus.in_valid && bus.in_ready;
    hit      = bus.out_ready[dest_q];
  end

  // IDLE/SEND sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      dest_q        <= '0;
      auto_q        <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= '0;
      bus.out_data  <= '0;
      bus.err       <= 1'b0;
      bus.xfer_cnt  <= '0;
      bus.busy      <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      bus.err <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (take && dest_ok) begin
            state         <= SEND;
            dest_q        <= dest_sel;
            auto_q        <= bus.in_auto;
            bus.out_data  <= bus.in_data;
            bus.out_valid <= ONE << dest_sel;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b1;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            to_cnt        <= '0;
`endif
          end else if (take) begin
            // illegal explicit index: drop word
            bus.err <= 1'b1;
          end
        end
        SEND: begin
          if (hit) begin
            state         <= IDLE;
            bus.out_valid <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.xfer_cnt  <= bus.xfer_cnt + 16'd1;
            if (auto_q)
              rr_ptr <= rr_nxt;
`ifdef DEMUX_SCHED_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            // stalled channel: drop, still skip it
            state         <= IDLE;
            bus.out_valid <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b1;
            if (auto_q)
              rr_ptr <= rr_nxt;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_stream_sched.sv
// Self-checking bench for demux_stream_sched.
// Table vectors, hand sequences, random words vs model.
module tb_demux_stream_sched;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  int rr  = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  demux_stream_sched_if #(
    .DATA_W(8), .NUM_OUT(2), .SEL_W(1)
  ) ia ();

  demux_stream_sched_if #(
    .DATA_W(8), .NUM_OUT(3), .SEL_W(2)
  ) ib ();

  demux_stream_sched #(
    .DATA_W(8), .NUM_OUT(2),
    .SEL_W(1), .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );

  demux_stream_sched #(
    .DATA_W(8), .NUM_OUT(3),
    .SEL_W(2), .TIMEOUT(TO)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  typedef struct {
    bit         au;
    bit         d;
    logic [7:0] data;
    int         stall;
    int         exp_d;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one word through dut_a; stall = cycles with
  // the addressed ready low before it goes high
  task automatic send_a(input bit au,
                        input bit d,
                        input logic [7:0] data,
                        input int stall,
                        input int exp_d);
    logic [1:0] oh;
    bit dropped;
    dropped = 0;
    oh = (exp_d == 0) ? 2'b01 : 2'b10;
    chk("idle_in_ready", ia.in_ready, 1);
    ia.in_valid  = 1'b1;
    ia.in_auto   = au;
    ia.in_dest   = d;
    ia.in_data   = data;
    ia.out_ready = 2'b00;
    tick();
    ia.in_valid = 1'b0;
    ia.in_data  = 8'($urandom);
    ia.in_dest  = 1'($urandom);
    ia.in_auto  = 1'($urandom);
    for (int c = 0; c <= stall; c++) begin
      chk("send_valid", ia.out_valid, oh);
      chk("send_data", ia.out_data, data);
      chk("send_in_ready", ia.in_ready, 0);
      chk("send_busy", ia.busy, 1);
      if (c < stall)
        ia.out_ready = ~oh;
      else
        ia.out_ready = oh | (2'($urandom) & ~oh);
      tick();
`ifdef DEMUX_SCHED_TIMEOUT_EN
      if (c == TO - 1 && c < stall) begin
        dropped = 1;
        break;
      end
`endif
    end
    ia.out_ready = 2'b00;
    if (au) rr = (rr + 1) % 2;
    if (!dropped) cnt++;
    chk("done_err", ia.err, 32'(dropped));
    chk("done_cnt", ia.xfer_cnt, cnt[15:0]);
    chk("done_valid", ia.out_valid, 0);
    chk("done_busy", ia.busy, 0);
    chk("done_in_ready", ia.in_ready, 1);
    if (dropped) begin
      tick();
      chk("err_width", ia.err, 0);
    end
  endtask

  initial begin
    tbl[0] = '{0, 1, 8'hA5, 0, 1};
    tbl[1] = '{1, 0, 8'h11, 0, 0};
    tbl[2] = '{1, 1, 8'h22, 0, 1};
    tbl[3] = '{1, 0, 8'h33, 0, 0};
    tbl[4] = '{1, 1, 8'h44, 0, 1};
    tbl[5] = '{0, 0, 8'h5A, 5, 0};
    tbl[6] = '{0, 1, 8'hC3, 2, 1};
    tbl[7] = '{1, 1, 8'h77, 0, 0};

    ia.in_valid = 0; ia.in_data = 0;
    ia.in_dest = 0; ia.in_auto = 0;
    ia.out_ready = 0;
    ib.in_valid = 0; ib.in_data = 0;
    ib.in_dest = 0; ib.in_auto = 0;
    ib.out_ready = 3'b111;

    tick();
    tick();
    chk("rst_in_ready", ia.in_ready, 0);
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_data", ia.out_data, 0);
    chk("rst_err", ia.err, 0);
    chk("rst_cnt", ia.xfer_cnt, 0);
    chk("rst_busy", ia.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", ia.in_ready, 1);

    foreach (tbl[i])
      send_a(tbl[i].au, tbl[i].d, tbl[i].data,
             tbl[i].stall, tbl[i].exp_d);

`ifdef DEMUX_SCHED_TIMEOUT_EN
    send_a(1, 0, 8'h99, 10, rr);
    send_a(1, 0, 8'h98, 0, rr);
`endif

    // reset in the middle of a SEND
    ia.in_valid = 1; ia.in_auto = 0;
    ia.in_dest = 1; ia.in_data = 8'h3C;
    tick();
    ia.in_valid = 0;
    chk("mid_valid", ia.out_valid, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ia.out_valid, 0);
    chk("mid_rst_ready", ia.in_ready, 0);
    chk("mid_rst_cnt", ia.xfer_cnt, 0);
    chk("mid_rst_busy", ia.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    cnt = 0;
    tick();
    chk("mid_post_ready", ia.in_ready, 1);
    chk("mid_post_valid", ia.out_valid, 0);

    for (int i = 0; i < 30; i++) begin
      bit au;
      bit d;
      au = 1'($urandom);
      d  = 1'($urandom);
      send_a(au, d, 8'($urandom),
             int'($urandom_range(0, 6)),
             au ? rr : int'(d));
    end

    // three-channel instance: illegal index
    ib.in_valid = 1; ib.in_auto = 0;
    ib.in_dest = 2; ib.in_data = 8'h5E;
    tick();
    ib.in_valid = 0;
    chk("b_valid", ib.out_valid, 3'b100);
    chk("b_data", ib.out_data, 8'h5E);
    tick();
    chk("b_cnt", ib.xfer_cnt, 1);
    ib.in_valid = 1; ib.in_dest = 3;
    ib.in_data = 8'hEE;
    tick();
    ib.in_valid = 0;
    chk("bad_err", ib.err, 1);
    chk("bad_valid", ib.out_valid, 0);
    chk("bad_ready", ib.in_ready, 1);
    chk("bad_cnt", ib.xfer_cnt, 1);
    chk("bad_busy", ib.busy, 0);
    tick();
    chk("bad_err_width", ib.err, 0);
    chk("bad_valid2", ib.out_valid, 0);
    ib.in_valid = 1; ib.in_auto = 1;
    ib.in_data = 8'h61;
    tick();
    ib.in_valid = 0;
    chk("b_auto_rr", ib.out_valid, 3'b001);
    tick();
    chk("b_cnt2", ib.xfer_cnt, 2);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
